// File: rtl/video_capture.sv
// ---------------------------------------------------------------------------
// video_capture
//   Captures a monochrome video stream into a frame buffer. The incoming
//   hsync/vsync/data wires are resynchronised to pixelclk. Line and frame
//   timing is recovered from the sync edges. Each visible pixel is emitted as
//   one write (waddr/wdata/we) addressed {row, col}.
//
// Ports
//   pixelclk   in   sole clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   hsyncin    in   line sync, active-high (falling edge starts a line)
//   vsyncin    in   frame sync, active-low on the wire (rising edge = end)
//   datain     in   pixel level
//   waddr      out  {row[15:0], col[15:0]} of the pixel being written
//   wdata      out  captured pixel
//   we         out  write strobe, one pixel per asserted cycle
//   frame_done out  one-cycle pulse after a completely captured frame
//   locked     out  high while the incoming timing matches the parameters
// ---------------------------------------------------------------------------
module video_capture #(
    parameter int HACTIVE = 640,
    parameter int HBACK   = 48,
    parameter int VACTIVE = 480,
    parameter int VBACK   = 33
) (
    input  logic        pixelclk,
    input  logic        rst_n,
    input  logic        hsyncin,
    input  logic        vsyncin,
    input  logic        datain,
    output logic [31:0] waddr,
    output logic        wdata,
    output logic        we,
    output logic        frame_done,
    output logic        locked
);

    localparam logic [15:0] HACT_LAST  = 16'(HACTIVE - 1);
    localparam logic [15:0] HBACK_LAST = 16'(HBACK - 1);
    localparam logic [15:0] VACT_LAST  = 16'(VACTIVE - 1);
    localparam logic [15:0] VBACK_LAST = 16'(VBACK - 1);

    typedef enum logic [1:0] {
        ST_WAIT_VSYNC,
        ST_VBACK,
        ST_ACTIVE
    } state_t;

    typedef enum logic [1:0] {
        LN_IDLE,
        LN_BACK,
        LN_PIX
    } line_t;

    // ---- input synchronizers ------------------------------------------------
    logic hs_p1_q, hs_p2_q, hs_prev_q;
    logic vs_p1_q, vs_p2_q, vs_prev_q;
    logic d_p1_q, d_p2_q;
    // Tracks how far valid pin samples have progressed through the chain
    // since reset release; the synchronizers hold 0 during reset, so a wire
    // that is already high must not be mistaken for a fresh rising edge.
    logic vld_p1_q, vld_p2_q, vld_p3_q;

    always_ff @(posedge pixelclk or negedge rst_n) begin
        if (!rst_n) begin
            hs_p1_q   <= 1'b0;
            hs_p2_q   <= 1'b0;
            hs_prev_q <= 1'b0;
            vs_p1_q   <= 1'b0;
            vs_p2_q   <= 1'b0;
            vs_prev_q <= 1'b0;
            d_p1_q    <= 1'b0;
            d_p2_q    <= 1'b0;
            vld_p1_q  <= 1'b0;
            vld_p2_q  <= 1'b0;
            vld_p3_q  <= 1'b0;
        end else begin
            hs_p1_q   <= hsyncin;
            hs_p2_q   <= hs_p1_q;
            hs_prev_q <= hs_p2_q;
            vs_p1_q   <= vsyncin;
            vs_p2_q   <= vs_p1_q;
            vs_prev_q <= vs_p2_q;
            d_p1_q    <= datain;
            d_p2_q    <= d_p1_q;
            vld_p1_q  <= 1'b1;
            vld_p2_q  <= vld_p1_q;
            vld_p3_q  <= vld_p2_q;
        end
    end

    // ---- sync events ----------------------------------------------------------
    logic hs_evt;
    logic vs_end;
    logic vs_low;

    assign hs_evt = hs_prev_q & ~hs_p2_q;
    assign vs_end = vld_p3_q & ~vs_prev_q & vs_p2_q;
    assign vs_low = ~vs_p2_q;

    // ---- frame / line state machine -------------------------------------------
    state_t      state_q;
    line_t       phase_q;
    logic [15:0] line_q;
    logic [15:0] col_q;
    logic        frame_ok_q;   // no line of the current frame was aborted
    logic [31:0] waddr_q;
    logic        wdata_q;
    logic        we_q;
    logic        frame_done_q;
    logic        locked_q;

    logic        line_busy;
    logic [15:0] row_start;

    assign line_busy = (phase_q != LN_IDLE);
    // An aborted line still consumes its row, so the replacement line
    // starts on the next row.
    assign row_start = line_busy ? (line_q + 16'd1) : line_q;

    always_ff @(posedge pixelclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_WAIT_VSYNC;
            phase_q      <= LN_IDLE;
            line_q       <= 16'd0;
            col_q        <= 16'd0;
            frame_ok_q   <= 1'b0;
            waddr_q      <= 32'd0;
            wdata_q      <= 1'b0;
            we_q         <= 1'b0;
            frame_done_q <= 1'b0;
            locked_q     <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_WAIT_VSYNC: begin
                    we_q    <= 1'b0;
                    phase_q <= LN_IDLE;
                    if (vs_end) begin
                        line_q     <= 16'd0;
                        frame_ok_q <= 1'b1;
                        state_q    <= (VBACK == 0) ? ST_ACTIVE : ST_VBACK;
                    end
                end

                ST_VBACK: begin
                    we_q <= 1'b0;
                    if (vs_low) begin
                        state_q  <= ST_WAIT_VSYNC;
                        locked_q <= 1'b0;
                    end else if (hs_evt) begin
                        if (line_q == VBACK_LAST) begin
                            line_q  <= 16'd0;
                            state_q <= ST_ACTIVE;
                        end else begin
                            line_q <= line_q + 16'd1;
                        end
                    end
                end

                ST_ACTIVE: begin
                    if (vs_low) begin
                        // Frame abort outranks a coincident hsync event.
                        state_q  <= ST_WAIT_VSYNC;
                        phase_q  <= LN_IDLE;
                        we_q     <= 1'b0;
                        locked_q <= 1'b0;
                    end else if (hs_evt) begin
                        col_q <= 16'd0;
                        if (line_busy) begin
                            locked_q   <= 1'b0;
                            frame_ok_q <= 1'b0;
                        end
                        if (line_busy && (line_q == VACT_LAST)) begin
                            // The aborted line was the last row: the frame is
                            // over but incomplete, so no frame_done.
                            we_q    <= 1'b0;
                            phase_q <= LN_IDLE;
                            line_q  <= 16'd0;
                            state_q <= ST_WAIT_VSYNC;
                        end else begin
                            line_q <= row_start;
                            if (HBACK == 0) begin
                                we_q    <= 1'b1;
                                phase_q <= LN_PIX;
                                waddr_q <= {row_start, 16'd0};
                                wdata_q <= d_p2_q;
                            end else begin
                                we_q    <= 1'b0;
                                phase_q <= LN_BACK;
                            end
                        end
                    end else begin
                        case (phase_q)
                            LN_BACK: begin
                                if (col_q == HBACK_LAST) begin
                                    col_q   <= 16'd0;
                                    we_q    <= 1'b1;
                                    phase_q <= LN_PIX;
                                    waddr_q <= {line_q, 16'd0};
                                    wdata_q <= d_p2_q;
                                end else begin
                                    col_q <= col_q + 16'd1;
                                end
                            end
                            LN_PIX: begin
                                // col_q is the column currently presented on waddr.
                                if (col_q == HACT_LAST) begin
                                    we_q    <= 1'b0;
                                    phase_q <= LN_IDLE;
                                    if (line_q == VACT_LAST) begin
                                        line_q  <= 16'd0;
                                        state_q <= ST_WAIT_VSYNC;
                                        if (frame_ok_q) begin
                                            frame_done_q <= 1'b1;
                                            locked_q     <= 1'b1;
                                        end
                                    end else begin
                                        line_q <= line_q + 16'd1;
                                    end
                                end else begin
                                    col_q   <= col_q + 16'd1;
                                    waddr_q <= {line_q, col_q + 16'd1};
                                    wdata_q <= d_p2_q;
                                end
                            end
                            default: begin
                                we_q <= 1'b0;
                            end
                        endcase
                    end
                end

                default: begin
                    state_q <= ST_WAIT_VSYNC;
                    phase_q <= LN_IDLE;
                    we_q    <= 1'b0;
                end
            endcase
        end
    end

    assign waddr      = waddr_q;
    assign wdata      = wdata_q;
    assign we         = we_q;
    assign frame_done = frame_done_q;
    assign locked     = locked_q;

endmodule

// File: tb/tb_video_capture.sv
// ---------------------------------------------------------------------------
// tb_video_capture
//   Scoreboard bench for video_capture with a small 8x4 frame. Every write the
//   stimulus is expected to cause is queued when the line is driven and
//   popped when the DUT raises we.
// ---------------------------------------------------------------------------
module tb_video_capture;

    localparam int HACT = 8;
    localparam int HBK  = 2;
    localparam int VACT = 4;
    localparam int VBK  = 1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        hsyncin;
    logic        vsyncin;
    logic        datain;
    logic [31:0] waddr;
    logic        wdata;
    logic        we;
    logic        frame_done;
    logic        locked;

    video_capture #(
        .HACTIVE(HACT),
        .HBACK  (HBK),
        .VACTIVE(VACT),
        .VBACK  (VBK)
    ) dut (
        .pixelclk  (clk),
        .rst_n     (rst_n),
        .hsyncin   (hsyncin),
        .vsyncin   (vsyncin),
        .datain    (datain),
        .waddr     (waddr),
        .wdata     (wdata),
        .we        (we),
        .frame_done(frame_done),
        .locked    (locked)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] addr;
        logic        data;
    } exp_t;

    exp_t sb[$];

    int n_cmp  = 0;
    int n_bad  = 0;
    int cyc    = 0;
    int wr_cnt = 0;
    int fd_cnt = 0;
    int lk_drop = 0;
    int drow   = 0;
    int dt     = 100;
    int last_fall = 0;
    int meas_diff = -1;
    bit meas_arm  = 1'b0;
    bit lk_watch_en = 1'b0;
    bit lk_watching = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic pix(input int r, input int c);
        return 1'((r ^ c) & 1);
    endfunction

    always @(posedge clk) cyc++;

    // Output monitor: sampled on the falling edge, away from register updates.
    always @(negedge clk) begin
        exp_t e;
        if (we) begin
            wr_cnt++;
            if (meas_arm) begin
                meas_diff = cyc - last_fall;
                meas_arm  = 1'b0;
            end
            if (sb.size() == 0) begin
                chk("spurious_we", {31'd0, we}, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("waddr", waddr, e.addr);
                chk("wdata", {31'd0, wdata}, {31'd0, e.data});
            end
        end
        if (frame_done) begin
            fd_cnt++;
            if (lk_watch_en) lk_watching = 1'b1;
        end
        if (lk_watching && !locked) lk_drop++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Drive the pixel belonging to the current line position, then advance.
    // Pixel c of a line is driven 2+c cycles after that line's hsync fall.
    task automatic drive_step();
        datain = (dt >= 2 && dt < 2 + HACT) ? pix(drow, dt - 2) : 1'b0;
        dt++;
        step();
    endtask

    task automatic push_row(input int row, input int n);
        for (int c = 0; c < n; c++) begin
            sb.push_back('{addr: {16'(row), 16'(c)}, data: pix(row, c)});
        end
    endtask

    task automatic hs_fall(input int row, input int hi);
        hsyncin = 1'b1;
        repeat (hi) drive_step();
        hsyncin   = 1'b0;
        last_fall = cyc;
        drow      = row;
        dt        = 0;
    endtask

    task automatic hline(input int row, input int npush, input int hi, input int lo);
        hs_fall(row, hi);
        if (npush > 0) push_row(row, npush);
        repeat (lo) drive_step();
    endtask

    // One frame: vsync pulse, VBACK blank lines, VACTIVE visible lines.
    // Optional disturbances on one row: vsync drop, extra hsync, or reset.
    task automatic frame(input int vs_ab, input int hs_ab, input int rst_ab);
        int hi;
        hsyncin = 1'b0;
        vsyncin = 1'b0;
        repeat (3) drive_step();
        vsyncin = 1'b1;
        repeat (2) drive_step();
        for (int v = 0; v < VBK; v++) hline(-1, 0, 4, 14);
        hi = 4;
        for (int r = 0; r < VACT; r++) begin
            if (r == hs_ab) begin
                // Extra hsync falls at t=7: pixels 0..4 land before the abort.
                hline(r, 5, hi, 6);
                hi = 1;
            end else if (r == vs_ab) begin
                hs_fall(r, hi);
                push_row(r, 3);
                repeat (5) drive_step();
                vsyncin = 1'b0;
                repeat (3) drive_step();
                chk("we_after_vs_abort", {31'd0, we}, 32'd0);
                repeat (4) drive_step();
                return;
            end else if (r == rst_ab) begin
                hs_fall(r, hi);
                push_row(r, 1);
                repeat (6) drive_step();
                rst_n = 1'b0;
                #1;
                chk("rst_we", {31'd0, we}, 32'd0);
                chk("rst_waddr", waddr, 32'd0);
                chk("rst_wdata", {31'd0, wdata}, 32'd0);
                chk("rst_frame_done", {31'd0, frame_done}, 32'd0);
                chk("rst_locked", {31'd0, locked}, 32'd0);
                vsyncin = 1'b1;
                hsyncin = 1'b0;
                repeat (3) drive_step();
                rst_n = 1'b1;
                return;
            end else begin
                hline(r, HACT, hi, 14);
                hi = 4;
            end
        end
    endtask

    int wr0;
    int fd0;

    initial begin
        rst_n   = 1'b1;
        hsyncin = 1'b0;
        vsyncin = 1'b1;
        datain  = 1'b0;
        #2 rst_n = 1'b0;
        repeat (3) step();
        chk("reset_we", {31'd0, we}, 32'd0);
        chk("reset_waddr", waddr, 32'd0);
        chk("reset_wdata", {31'd0, wdata}, 32'd0);
        chk("reset_frame_done", {31'd0, frame_done}, 32'd0);
        chk("reset_locked", {31'd0, locked}, 32'd0);
        rst_n = 1'b1;
        repeat (5) step();

        // Clean checkerboard frame with first-write latency measurement.
        wr0 = wr_cnt; fd0 = fd_cnt;
        meas_arm = 1'b1;
        frame(-1, -1, -1);
        chk("clean_writes", 32'(wr_cnt - wr0), 32'(HACT * VACT));
        chk("clean_frame_done", 32'(fd_cnt - fd0), 32'd1);
        chk("clean_locked", {31'd0, locked}, 32'd1);
        chk("clean_sb_drained", 32'(sb.size()), 32'd0);
        chk("first_we_latency", 32'(meas_diff), 32'(2 + HBK + 1));

        // Vsync dropped during row 2.
        wr0 = wr_cnt; fd0 = fd_cnt;
        frame(2, -1, -1);
        chk("vsab_writes", 32'(wr_cnt - wr0), 32'(2 * HACT + 3));
        chk("vsab_frame_done", 32'(fd_cnt - fd0), 32'd0);
        chk("vsab_locked", {31'd0, locked}, 32'd0);
        chk("vsab_sb_drained", 32'(sb.size()), 32'd0);

        // Recovery frame relocks.
        wr0 = wr_cnt; fd0 = fd_cnt;
        frame(-1, -1, -1);
        chk("relock_writes", 32'(wr_cnt - wr0), 32'(HACT * VACT));
        chk("relock_frame_done", 32'(fd_cnt - fd0), 32'd1);
        chk("relock_locked", {31'd0, locked}, 32'd1);

        // Extra hsync mid-line in row 1.
        wr0 = wr_cnt; fd0 = fd_cnt;
        frame(-1, 1, -1);
        chk("hsab_writes", 32'(wr_cnt - wr0), 32'(3 * HACT + 5));
        chk("hsab_frame_done", 32'(fd_cnt - fd0), 32'd0);
        chk("hsab_locked", {31'd0, locked}, 32'd0);
        chk("hsab_sb_drained", 32'(sb.size()), 32'd0);

        // Reset mid-line, then lines without a vsync low-high cycle.
        wr0 = wr_cnt; fd0 = fd_cnt;
        frame(-1, -1, 1);
        for (int i = 0; i < 6; i++) hline(-1, 0, 4, 14);
        chk("postrst_writes", 32'(wr_cnt - wr0), 32'(HACT + 1));
        chk("postrst_frame_done", 32'(fd_cnt - fd0), 32'd0);
        chk("postrst_sb_drained", 32'(sb.size()), 32'd0);

        // Three back-to-back frames.
        wr0 = wr_cnt; fd0 = fd_cnt;
        lk_watch_en = 1'b1;
        for (int f = 0; f < 3; f++) frame(-1, -1, -1);
        lk_watch_en = 1'b0;
        lk_watching = 1'b0;
        chk("b2b_writes", 32'(wr_cnt - wr0), 32'(3 * HACT * VACT));
        chk("b2b_frame_done", 32'(fd_cnt - fd0), 32'd3);
        chk("b2b_locked_drops", 32'(lk_drop), 32'd0);
        chk("b2b_locked", {31'd0, locked}, 32'd1);
        chk("b2b_sb_drained", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
